// File: rtl/calib_sum_if.sv
`default_nettype none
// ============================================================================
//  Module      : calib_sum_if
//  Description : Byte-stream / result bundle for calib_sum.
//                master = stream driver + result checker side
//                slave  = calib_sum
//  Signals     : input_valid, char_in[7:0], input_last, mode_spelled, clear
//                (driver -> block); input_ready, result[RESULT_W-1:0],
//                line_count[LINE_W-1:0], output_valid (block -> driver)
//  Revision    : 1.0 - initial release
// ============================================================================
interface calib_sum_if #(
  parameter int RESULT_W = 64,
  parameter int LINE_W   = 16
);

  logic                input_valid;
  logic [7:0]          char_in;
  logic                input_last;
  logic                input_ready;
  logic                mode_spelled;
  logic                clear;
  logic [RESULT_W-1:0] result;
  logic [LINE_W-1:0]   line_count;
  logic                output_valid;

  modport master (
    output input_valid, char_in, input_last, mode_spelled, clear,
    input  input_ready, result, line_count, output_valid
  );

  modport slave (
    input  input_valid, char_in, input_last, mode_spelled, clear,
    output input_ready, result, line_count, output_valid
  );

endinterface
`default_nettype wire

// File: rtl/calib_sum.sv
`default_nettype none
// ============================================================================
//  Module      : calib_sum
//  Description : Streaming ASCII line-calibration accumulator. Each line adds
//                10*first_digit + last_digit to a running sum. Digits are
//                '0'..'9', plus spelled words "one".."nine" when the spelled
//                mode is latched at the start of a stream.
//  Ports       : clk          - clock
//                rst          - asynchronous active-high reset
//                bus (slave)  - byte stream in (valid/ready/last), mode and
//                               clear controls, result/line_count/output_valid
//  Revision    : 1.0 - initial release
// ============================================================================
module calib_sum #(
  parameter int RESULT_W = 64,
  parameter int LINE_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  calib_sum_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SCAN_FIRST = 2'd1,
    ST_SCAN_LAST  = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  localparam logic [7:0] c_NEWLINE = 8'h0A;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [3:0]          first_q, first_d;
  logic [3:0]          last_q, last_d;
  logic [31:0]         hist_q, hist_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [LINE_W-1:0]   count_q, count_d;

  logic       w_accept;
  logic       w_mode_eff;
  logic       w_is_nl;
  logic       w_is_num;
  logic [3:0] w_word_d;
  logic       w_hit;
  logic [3:0] w_digit;
  logic [3:0] w_first_n;
  logic [3:0] w_last_n;
  logic [6:0] w_line_val;
  logic       w_commit;

  // Match a spelled digit ending at the current byte. The window holds the
  // four previous bytes of the line followed by the current byte, so the
  // longest word (five letters) fits exactly. Word endings are distinct, so
  // at most one word can match at a given position.
  function automatic logic [3:0] word_digit(input logic [39:0] w);
    logic [3:0] d;
    d = 4'd0;
    if      (w[23:0] == "one")   d = 4'd1;
    else if (w[23:0] == "two")   d = 4'd2;
    else if (w[39:0] == "three") d = 4'd3;
    else if (w[31:0] == "four")  d = 4'd4;
    else if (w[31:0] == "five")  d = 4'd5;
    else if (w[23:0] == "six")   d = 4'd6;
    else if (w[39:0] == "seven") d = 4'd7;
    else if (w[39:0] == "eight") d = 4'd8;
    else if (w[31:0] == "nine")  d = 4'd9;
    return d;
  endfunction

  assign bus.input_ready  = (state_q != ST_DONE) && !bus.clear;
  assign bus.result       = result_q;
  assign bus.line_count   = count_q;
  assign bus.output_valid = (state_q == ST_DONE);

  always_comb begin
    w_accept   = bus.input_valid && bus.input_ready;
    // The mode pin is live only for the byte that opens a stream.
    w_mode_eff = (state_q == ST_IDLE) ? bus.mode_spelled : mode_q;
    w_is_nl    = (bus.char_in == c_NEWLINE);
    w_is_num   = (bus.char_in >= 8'h30) && (bus.char_in <= 8'h39);
    w_word_d   = word_digit({hist_q, bus.char_in});
    w_hit      = w_is_num || (w_mode_eff && (w_word_d != 4'd0));
    w_digit    = w_is_num ? bus.char_in[3:0] : w_word_d;
    // First digit only captured while the line has none yet.
    w_first_n  = (w_hit && (state_q != ST_SCAN_LAST)) ? w_digit : first_q;
    w_last_n   = w_hit ? w_digit : last_q;
    // Digits are zero when the line had none, so the sum naturally adds 0.
    w_line_val = (7'd10 * {3'b000, w_first_n}) + {3'b000, w_last_n};
    // A non-newline last byte always leaves a non-empty open line, so it
    // always flushes; a newline last byte is its own (single) line end.
    w_commit   = w_is_nl || bus.input_last;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    first_d  = first_q;
    last_d   = last_q;
    hist_d   = hist_q;
    result_d = result_q;
    count_d  = count_q;

    if (bus.clear) begin
      state_d  = ST_IDLE;
      mode_d   = 1'b0;
      first_d  = 4'd0;
      last_d   = 4'd0;
      hist_d   = 32'd0;
      result_d = '0;
      count_d  = '0;
    end else if (w_accept) begin
      if (state_q == ST_IDLE) begin
        mode_d = bus.mode_spelled;
      end
      first_d = w_first_n;
      last_d  = w_last_n;
      hist_d  = {hist_q[23:0], bus.char_in};
      if (w_hit) begin
        state_d = ST_SCAN_LAST;
      end else if (state_q == ST_IDLE) begin
        state_d = ST_SCAN_FIRST;
      end

      if (w_commit) begin
        result_d = result_q + RESULT_W'(w_line_val);
        if (count_q != {LINE_W{1'b1}}) begin
          count_d = count_q + LINE_W'(1);
        end
        first_d = 4'd0;
        last_d  = 4'd0;
        hist_d  = 32'd0;
        state_d = bus.input_last ? ST_DONE : ST_SCAN_FIRST;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      first_q  <= 4'd0;
      last_q   <= 4'd0;
      hist_q   <= 32'd0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      first_q  <= first_d;
      last_q   <= last_d;
      hist_q   <= hist_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calib_sum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calib_sum
//  Description : Scoreboard bench for calib_sum. Streams are issued by the
//                stimulus process, which pushes the reference result; a
//                separate monitor pops and compares when output_valid rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calib_sum;

  localparam int RESULT_W = 64;
  localparam int LINE_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  calib_sum_if #(.RESULT_W(RESULT_W), .LINE_W(LINE_W)) bus ();

  calib_sum #(.RESULT_W(RESULT_W), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_res[$];
  int          exp_cnt[$];
  logic        ov_seen = 1'b0;

  string words[9] = '{"one", "two", "three", "four", "five",
                      "six", "seven", "eight", "nine"};

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: split into lines, find every digit occurrence inside each
  // line (words only in spelled mode), add 10*first+last per line; an
  // unterminated non-empty tail counts as a line.
  function automatic void model(input string s, input bit mode,
                                output logic [63:0] sum, output int cnt);
    int start;
    int f, l;
    bit seen;
    sum = 0; cnt = 0; start = 0; f = 0; l = 0; seen = 0;
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      int d;
      c = s[i];
      if (c == 8'h0A) begin
        sum = sum + 64'(seen ? (10 * f + l) : 0);
        cnt++;
        seen = 0; start = i + 1;
      end else begin
        d = -1;
        if (c >= "0" && c <= "9") d = c - "0";
        else if (mode) begin
          for (int w = 0; w < 9; w++) begin
            int len;
            len = words[w].len();
            if (i - start + 1 >= len && s.substr(i - len + 1, i) == words[w])
              d = w + 1;
          end
        end
        if (d >= 0) begin
          if (!seen) f = d;
          l = d;
          seen = 1;
        end
      end
    end
    if (start < s.len()) begin
      sum = sum + 64'(seen ? (10 * f + l) : 0);
      cnt++;
    end
    if (cnt > 65535) cnt = 65535;
  endfunction

  // Monitor: one comparison pair per rising output_valid.
  always @(negedge clk) begin
    if (bus.output_valid && !ov_seen) begin
      if (exp_res.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got result %0d, expected no completion",
                 bus.result);
      end else begin
        check("done_result", bus.result, exp_res.pop_front());
        check("done_line_count", 64'(bus.line_count), 64'(exp_cnt.pop_front()));
      end
    end
    ov_seen <= bus.output_valid;
  end

  task automatic idle_inputs();
    bus.input_valid  = 1'b0;
    bus.char_in      = 8'h00;
    bus.input_last   = 1'b0;
    bus.clear        = 1'b0;
  endtask

  task automatic run_stream(input string s, input bit mode, input bit with_last);
    logic [63:0] er;
    int ec;
    if (with_last) begin
      model(s, mode, er, ec);
      exp_res.push_back(er);
      exp_cnt.push_back(ec);
    end
    bus.mode_spelled = mode;
    for (int i = 0; i < s.len(); i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        bus.input_valid = 1'b0;
        bus.char_in     = 8'($urandom);
        bus.input_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      bus.input_valid = 1'b1;
      bus.char_in     = s[i];
      bus.input_last  = with_last && (i == s.len() - 1);
      @(posedge clk); #1;
      bus.input_valid = 1'b0;
      bus.input_last  = 1'b0;
      // Mode changes after the opening byte must have no effect.
      if (i == 0) bus.mode_spelled = 1'($urandom);
    end
  endtask

  // Clear pulse with a competing byte that must not be accepted.
  task automatic pulse_clear();
    @(posedge clk); #1;
    bus.clear       = 1'b1;
    bus.input_valid = 1'b1;
    bus.char_in     = "9";
    bus.input_last  = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.mode_spelled = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_result", bus.result, 64'd0);
    check("reset_line_count", 64'(bus.line_count), 64'd0);
    check("reset_output_valid", 64'(bus.output_valid), 64'd0);
    check("reset_input_ready", 64'(bus.input_ready), 64'd1);

    run_stream("1abc2\npqr3stu8vwx\na1b2c3d4e5f\ntreb7uchet\n", 1'b0, 1'b1);
    pulse_clear();
    run_stream("two1nine\neightwothree\nabcone2threexyz\nxtwone3four\n4nineeightseven2\nzoneight234\n7pqrstsixteen\n", 1'b1, 1'b1);
    pulse_clear();
    run_stream("two1nine\neightwothree\nabcone2threexyz\nxtwone3four\n4nineeightseven2\nzoneight234\n7pqrstsixteen\n", 1'b0, 1'b1);
    pulse_clear();

    // Unterminated last line, then bytes offered while done.
    run_stream("ab\n9x", 1'b0, 1'b1);
    @(negedge clk);
    check("done_input_ready", 64'(bus.input_ready), 64'd0);
    run_stream("7\n", 1'b0, 1'b1);
    exp_res.delete();
    exp_cnt.delete();
    @(negedge clk);
    check("frozen_result", bus.result, 64'd99);
    check("frozen_line_count", 64'(bus.line_count), 64'd2);
    check("frozen_output_valid", 64'(bus.output_valid), 64'd1);
    pulse_clear();

    run_stream("oneight\non\ne\n", 1'b1, 1'b1);
    pulse_clear();

    // Abort an open line with clear.
    run_stream("5", 1'b0, 1'b0);
    pulse_clear();
    @(negedge clk);
    check("clear_result", bus.result, 64'd0);
    check("clear_line_count", 64'(bus.line_count), 64'd0);
    check("clear_output_valid", 64'(bus.output_valid), 64'd0);
    check("clear_input_ready", 64'(bus.input_ready), 64'd1);
    run_stream("7\n", 1'b0, 1'b1);
    pulse_clear();

    // Asynchronous reset in the middle of a line.
    run_stream("12\n3", 1'b0, 1'b0);
    @(negedge clk);
    check("midline_result", bus.result, 64'd12);
    check("midline_line_count", 64'(bus.line_count), 64'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_result", bus.result, 64'd0);
    check("async_rst_line_count", 64'(bus.line_count), 64'd0);
    check("async_rst_output_valid", 64'(bus.output_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Randomized streams.
    for (int t = 0; t < 30; t++) begin
      string alpha;
      string s;
      int len;
      alpha = "0123456789onetwhrfuivsxg\nab\r";
      s = "";
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        byte c;
        c = alpha[$urandom_range(0, alpha.len() - 1)];
        s = $sformatf("%s%c", s, c);
      end
      run_stream(s, 1'($urandom), 1'b1);
      pulse_clear();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_res.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
